// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/execute/writeback sequencing with a req/ready memory stall.
// Optional macro ILLEGAL_INSTR_EN adds an absorbing ILLEGAL state and the o_illegal_instr output.
module main_fsm #(
  parameter int OPCODE_WIDTH = 7,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_branch_taken,
  input  logic                    i_mem_ready,
  output logic                    o_mem_req,
  output logic                    o_mem_write_en,
  output logic                    o_adr_src,
  output logic                    o_instr_write_en,
  output logic                    o_pc_write,
  output logic                    o_reg_write_en,
  output logic [SEL_WIDTH-1:0]    o_alu_src_a,
  output logic [SEL_WIDTH-1:0]    o_alu_src_b,
  output logic [SEL_WIDTH-1:0]    o_result_src,
  output logic [1:0]              o_alu_op,
  output logic [3:0]              o_dbg_state
`ifdef ILLEGAL_INSTR_EN
  , output logic                  o_illegal_instr
`endif
);

  // Memory handshake: o_mem_req stays high in FETCH/MEMREAD/MEMWRITE until a cycle
  // with i_mem_ready high; that cycle completes the access and the FSM moves on.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    LUI      = 4'd8,
    AUIPC    = 4'd9,
    ALUWB    = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JALR1    = 4'd13,
    JALR2    = 4'd14
`ifdef ILLEGAL_INSTR_EN
    , ILLEGAL = 4'd15
`endif
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE  = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ITYPE  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = OPCODE_WIDTH'(7'b0010111);

  localparam logic [SEL_WIDTH-1:0] SEL_IN1 = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_IN2 = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_IN3 = SEL_WIDTH'(2);

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BRCMP = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    o_mem_req        = 1'b0;
    o_mem_write_en   = 1'b0;
    o_adr_src        = 1'b0;
    o_instr_write_en = 1'b0;
    o_pc_write       = 1'b0;
    o_reg_write_en   = 1'b0;
    o_alu_src_a      = SEL_IN1;
    o_alu_src_b      = SEL_IN1;
    o_result_src     = SEL_IN1;
    o_alu_op         = ALU_ADD;
`ifdef ILLEGAL_INSTR_EN
    o_illegal_instr  = 1'b0;
`endif

    case (state_q)
      FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = SEL_IN3;
        o_result_src = SEL_IN3;
        if (i_mem_ready) begin
          o_instr_write_en = 1'b1;
          o_pc_write       = 1'b1;
          state_d          = DECODE;
        end
      end
      DECODE: begin
        o_alu_src_a = SEL_IN2;
        o_alu_src_b = SEL_IN2;
        case (i_opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR1;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
`ifdef ILLEGAL_INSTR_EN
          default:           state_d = ILLEGAL;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        o_alu_src_a = SEL_IN3;
        o_alu_src_b = SEL_IN2;
        state_d     = (i_opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        o_result_src   = SEL_IN2;
        o_reg_write_en = 1'b1;
        state_d        = FETCH;
      end
      MEMWRITE: begin
        o_mem_req      = 1'b1;
        o_mem_write_en = 1'b1;
        o_adr_src      = 1'b1;
        if (i_mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        o_alu_src_a = SEL_IN3;
        o_alu_op    = ALU_FUNCT;
        state_d     = ALUWB;
      end
      EXECUTEI: begin
        o_alu_src_a = SEL_IN3;
        o_alu_src_b = SEL_IN2;
        o_alu_op    = ALU_FUNCT;
        state_d     = ALUWB;
      end
      LUI: begin
        o_alu_src_b = SEL_IN2;
        o_alu_op    = ALU_PASSB;
        state_d     = ALUWB;
      end
      AUIPC: begin
        o_alu_src_a = SEL_IN2;
        o_alu_src_b = SEL_IN2;
        state_d     = ALUWB;
      end
      ALUWB: begin
        o_reg_write_en = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        o_alu_src_a = SEL_IN3;
        o_alu_op    = ALU_BRCMP;
        o_pc_write  = i_branch_taken;
        state_d     = FETCH;
      end
      JAL: begin
        // PC takes the target precomputed in DECODE while the ALU forms OldPC+4 for rd.
        o_alu_src_a = SEL_IN2;
        o_alu_src_b = SEL_IN3;
        o_pc_write  = 1'b1;
        state_d     = ALUWB;
      end
      JALR1: begin
        o_alu_src_a = SEL_IN3;
        o_alu_src_b = SEL_IN2;
        state_d     = JALR2;
      end
      JALR2: begin
        o_alu_src_a = SEL_IN2;
        o_alu_src_b = SEL_IN3;
        o_pc_write  = 1'b1;
        state_d     = ALUWB;
      end
`ifdef ILLEGAL_INSTR_EN
      ILLEGAL: begin
        o_illegal_instr = 1'b1;
        state_d         = ILLEGAL;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Reset aborts any access in flight: no enables fire, selects park on FETCH values.
    if (rst) begin
      state_d          = FETCH;
      o_mem_req        = 1'b0;
      o_mem_write_en   = 1'b0;
      o_adr_src        = 1'b0;
      o_instr_write_en = 1'b0;
      o_pc_write       = 1'b0;
      o_reg_write_en   = 1'b0;
      o_alu_src_a      = SEL_IN1;
      o_alu_src_b      = SEL_IN3;
      o_result_src     = SEL_IN3;
      o_alu_op         = ALU_ADD;
`ifdef ILLEGAL_INSTR_EN
      o_illegal_instr  = 1'b0;
`endif
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle RV32I control FSM; sits directly upstream of the datapath's 3-to-1 select muxes (ALU A/B source, result source) and its register/memory write enables.
- Decodes opcode from the instruction register, sequences FETCH/DECODE/EXECUTE/WRITEBACK, and stalls on a req/ready memory handshake.
- Mux-select encoding matches the datapath muxes: 2'b00 selects input 1, 2'b01 selects input 2, 2'b1x selects input 3.

Parameters:
- OPCODE_WIDTH, 7, width of instruction opcode field.
- SEL_WIDTH, 2, width of each mux select output.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- i_opcode  input  OPCODE_WIDTH  instr[6:0] from instruction register.
- i_branch_taken  input  1  ALU branch-condition result, valid in BRANCH.
- i_mem_ready  input  1  memory completion pulse for current request.
- o_mem_req  output  1  memory access request.
- o_mem_write_en  output  1  store enable, qualifies o_mem_req.
- o_adr_src  output  1  memory address: 0 = PC, 1 = ALUOut.
- o_instr_write_en  output  1  load instruction register and OldPC.
- o_pc_write  output  1  PC load enable.
- o_reg_write_en  output  1  register-file write enable.
- o_alu_src_a  output  SEL_WIDTH  00 PC, 01 OldPC, 10 RD1.
- o_alu_src_b  output  SEL_WIDTH  00 RD2, 01 ImmExt, 10 constant 4.
- o_result_src  output  SEL_WIDTH  00 ALUOut, 01 ReadData, 10 ALUResult.
- o_alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded, 11 pass B.

Behaviour:
- State register only; all outputs are combinational from state (plus i_mem_ready / i_branch_taken where noted). Unlisted outputs are 0.
- rst high: state <= FETCH next edge. While rst high, pc_write, instr_write_en, reg_write_en, mem_write_en and mem_req are forced 0. Selects show FETCH values.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - Wait here while !i_mem_ready.
  - On i_mem_ready: instr_write_en=1 and pc_write=1 in that same cycle, then -> DECODE.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch/jal target precompute). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI.
  - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR1; 0110111 -> LUI; 0010111 -> AUIPC.
  - Other -> FETCH.
- MEMADR: src_a=10, src_b=01, alu_op=00. Load -> MEMREAD, store -> MEMWRITE (opcode held stable by IR).
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for i_mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write_en=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write_en=1, adr_src=1, result_src=00. Held until i_mem_ready -> FETCH.
- EXECUTER: src_a=10, src_b=00, alu_op=10 -> ALUWB.
- EXECUTEI: src_a=10, src_b=01, alu_op=10 -> ALUWB.
- LUI: src_b=01, alu_op=11 -> ALUWB.
- AUIPC: src_a=01, src_b=01, alu_op=00 -> ALUWB.
- ALUWB: result_src=00, reg_write_en=1 -> FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00. pc_write = i_branch_taken. -> FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (rd = OldPC+4).
- JALR1: src_a=10, src_b=01, alu_op=00 -> JALR2.
- JALR2: src_a=01, src_b=10, result_src=00, pc_write=1 -> ALUWB.
- Latency: R/I/LUI/AUIPC = 4 cycles; load = 5; store = 4; branch = 3; JAL = 4; JALR = 5. Each memory wait cycle adds 1.
- i_mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- rst asserted mid-access aborts it: no write enable fires in that cycle.

Optional Feature:
- Macro ILLEGAL_INSTR_EN. Adds output o_illegal_instr (1 bit) and an ILLEGAL state.
- Defined: unknown opcode in DECODE -> ILLEGAL. ILLEGAL is absorbing (exit only by rst), with o_illegal_instr=1 and all enables 0.
- Undefined: unknown opcode -> FETCH (executed as NOP); port absent.

Test Plan:
- rst=1 for 2 cycles with i_mem_ready=1 -> all enables 0; then FETCH with src_b=10, mem_req=1.
- R-type (0110011), ready on first FETCH cycle -> states FETCH, DECODE, EXECUTER, ALUWB. reg_write_en=1 only in cycle 4; alu_op=10 in cycle 3.
- Load with i_mem_ready delayed 3 cycles in MEMREAD -> adr_src=1 and mem_req held 4 cycles; reg_write_en=1 with result_src=01 exactly once.
- Store -> mem_write_en=1 only while in MEMWRITE; reg_write_en never asserted.
- Branch with i_branch_taken=0, then a second branch with =1 -> pc_write 0 then 1 in the BRANCH cycle.
- Opcode 1111111 -> returns to FETCH. With ILLEGAL_INSTR_EN: o_illegal_instr=1 stays set until rst, which clears it and restarts at FETCH.
